// File: rtl/ext_mem_sequencer.sv
// ext_mem_sequencer
//   Turns a single CPU memory request into a pin-level sequence for an
//   off-chip memory that has its own address register. The address is
//   loaded one byte at a time, low byte first. A write then pulses the RAM
//   write strobe. A read waits a programmable number of cycles and then
//   captures pin_in.
//
// Ports
//   CLK, rst          rising-edge clock; synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = write, 0 = read
//   req_addr          16-bit target address
//   req_wdata         write byte
//   wait_cfg          read wait-state count W (the read waits W+1 cycles)
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         data from the most recent completed read
//   busy              a transaction is in progress
//   pin_out           byte driven to the memory pins
//   pin_mar_we        address-register load strobe
//   pin_addr_hi       0 = low address byte, 1 = high address byte on pin_out
//   pin_ram_we        RAM write strobe
//   pin_in            read data returned from the memory
module ext_mem_sequencer #(
  parameter int WAIT_W = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [7:0]        req_wdata,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic [7:0]        pin_out,
  output logic              pin_mar_we,
  output logic              pin_addr_hi,
  output logic              pin_ram_we,
  input  logic [7:0]        pin_in
);

  typedef enum logic [2:0] {IDLE, ALO, AHI, WR, WT} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [15:0]         addr_q;
  logic                we_q;
  logic [7:0]          wdata_q;
  logic                accept;

  // rst has priority over accept, so ready is masked while reset is high.
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ALO;
          // The wait count is captured with the request, so later changes to
          // wait_cfg cannot affect this transaction.
          cnt_d   = wait_cfg;
        end
      end
      ALO: state_d = AHI;
      AHI: state_d = we_q ? WR : WT;
      WR: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
      end
      WT: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rdata_d     = pin_in;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Request fields only matter while busy, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
  end

  // Pin decode depends only on the state register and the latched request.
  always_comb begin
    pin_out     = 8'h00;
    pin_mar_we  = 1'b0;
    pin_addr_hi = 1'b0;
    pin_ram_we  = 1'b0;
    case (state_q)
      ALO: begin
        pin_out    = addr_q[7:0];
        pin_mar_we = 1'b1;
      end
      AHI: begin
        pin_out     = addr_q[15:8];
        pin_mar_we  = 1'b1;
        pin_addr_hi = 1'b1;
      end
      WR: begin
        pin_out    = wdata_q;
        pin_ram_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ext_mem_sequencer.sv
module tb_ext_mem_sequencer;

  logic        CLK = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [1:0]  wait_cfg;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy;
  logic [7:0]  pin_out;
  logic        pin_mar_we;
  logic        pin_addr_hi;
  logic        pin_ram_we;
  logic [7:0]  pin_in;

  int n_tests = 0;
  int n_fail  = 0;

  ext_mem_sequencer #(.WAIT_W(2)) dut (
    .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .wait_cfg(wait_cfg),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .pin_out(pin_out), .pin_mar_we(pin_mar_we),
    .pin_addr_hi(pin_addr_hi), .pin_ram_we(pin_ram_we), .pin_in(pin_in)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compact pin check: {pin_out, mar_we, addr_hi, ram_we}.
  task automatic check_pins(input string tag, input logic [7:0] po,
                            input logic mw, input logic hi, input logic rw);
    check({tag, ".pins"}, {21'd0, pin_out, pin_mar_we, pin_addr_hi, pin_ram_we},
          {21'd0, po, mw, hi, rw});
    check({tag, ".exclusive"}, {31'd0, pin_mar_we & pin_ram_we}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0;
    req_wdata = 8'h0; wait_cfg = 2'd0; pin_in = 8'h00;
    tick(); tick();

    // Reset state
    check("rst.busy", {31'd0, busy}, 0);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst.rdata", {24'd0, rsp_rdata}, 0);
    check("rst.ready_low", {31'd0, req_ready}, 0);
    check_pins("rst", 8'h00, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("idle.ready", {31'd0, req_ready}, 1);

    // Write 0x12AB <= 0x5C
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h12AB; req_wdata = 8'h5C;
    tick();
    req_valid = 1'b0; req_addr = 16'hFFFF; req_wdata = 8'h00;
    check_pins("wr.alo", 8'hAB, 1, 0, 0);
    check("wr.busy", {31'd0, busy}, 1);
    check("wr.ready", {31'd0, req_ready}, 0);
    tick();
    check_pins("wr.ahi", 8'h12, 1, 1, 0);
    tick();
    check_pins("wr.wr", 8'h5C, 0, 0, 1);
    check("wr.no_rsp_t3", {31'd0, rsp_valid}, 0);
    tick();
    check("wr.rsp_t4", {31'd0, rsp_valid}, 1);
    check("wr.idle_busy", {31'd0, busy}, 0);
    check_pins("wr.idle", 8'h00, 0, 0, 0);
    check("wr.rdata_kept", {24'd0, rsp_rdata}, 32'h00);

    // Read 0x0040, W=0, pin_in=0xA5
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040; wait_cfg = 2'd0; pin_in = 8'hA5;
    tick();
    check("rd0.rsp_pulse_once", {31'd0, rsp_valid}, 0);
    req_valid = 1'b0;
    check_pins("rd0.alo", 8'h40, 1, 0, 0);
    tick();
    check_pins("rd0.ahi", 8'h00, 1, 1, 0);
    tick();
    check_pins("rd0.wt", 8'h00, 0, 0, 0);
    check("rd0.wt_busy", {31'd0, busy}, 1);
    tick();
    check("rd0.rsp_t4", {31'd0, rsp_valid}, 1);
    check("rd0.rdata", {24'd0, rsp_rdata}, 32'hA5);
    tick();
    check("rd0.rsp_one_cycle", {31'd0, rsp_valid}, 0);

    // Read W=3, wait_cfg changed after accept
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0300; wait_cfg = 2'd3; pin_in = 8'h3C;
    tick();
    req_valid = 1'b0; wait_cfg = 2'd0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("rd3.latency", n, 7);
    check("rd3.rdata", {24'd0, rsp_rdata}, 32'h3C);

    // Held req_valid across a read, then a write accepted in the rsp cycle
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0100; wait_cfg = 2'd1; pin_in = 8'h77;
    tick();                                  // t+1 ALO
    check("hold.ready_alo", {31'd0, req_ready}, 0);
    tick();                                  // t+2 AHI
    check("hold.ready_ahi", {31'd0, req_ready}, 0);
    tick();                                  // t+3 WT
    check("hold.wt3", {31'd0, busy}, 1);
    tick();                                  // t+4 WT
    check("hold.wt4", {31'd0, busy}, 1);
    check("hold.no_early_rsp", {31'd0, rsp_valid}, 0);
    req_we = 1'b1; req_addr = 16'h2211; req_wdata = 8'h99;
    tick();                                  // t+5 IDLE, rsp_valid
    check("hold.rsp", {31'd0, rsp_valid}, 1);
    check("hold.rdata", {24'd0, rsp_rdata}, 32'h77);
    check("hold.ready_rsp", {31'd0, req_ready}, 1);
    tick();                                  // second transaction ALO
    req_valid = 1'b0;
    check_pins("b2b.alo", 8'h11, 1, 0, 0);
    tick();
    check_pins("b2b.ahi", 8'h22, 1, 1, 0);
    tick();
    check_pins("b2b.wr", 8'h99, 0, 0, 1);
    tick();
    check("b2b.rsp", {31'd0, rsp_valid}, 1);
    check("b2b.rdata_unchanged", {24'd0, rsp_rdata}, 32'h77);

    // Reset during AHI of a write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h3456; req_wdata = 8'hEE;
    tick();
    req_valid = 1'b0;
    tick();
    check_pins("abort.ahi", 8'h34, 1, 1, 0);
    rst = 1'b1;
    #1;
    check("abort.ready_in_rst", {31'd0, req_ready}, 0);
    tick();
    check_pins("abort.after", 8'h00, 0, 0, 0);
    check("abort.busy", {31'd0, busy}, 0);
    check("abort.rsp", {31'd0, rsp_valid}, 0);
    check("abort.rdata", {24'd0, rsp_rdata}, 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0001;
    #1;
    check("abort.ready_rst_idle", {31'd0, req_ready}, 0);
    tick();
    check("abort.no_accept_in_rst", {31'd0, busy}, 0);
    rst = 1'b0; req_valid = 1'b0;
    tick();
    check("abort.still_idle", {31'd0, busy}, 0);
    check("abort.no_rsp_later", {31'd0, rsp_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
